// File: rtl/datamem_arb_pkg.sv
// datamem_arb_pkg: shared types, byte-enable encodings and the access legality rule
package datamem_arb_pkg;
  typedef enum logic {IDLE, RD_RESP} state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic is_legal(input logic [3:0] byteenable, input logic [1:0] addr);
    return (byteenable == BE_BYTE) ||
           (byteenable == BE_HALF && !addr[0]) ||
           (byteenable == BE_WORD && addr == 2'b00);
  endfunction
endpackage

// File: rtl/datamem_arb_rr.sv
// datamem_arb_rr: 2-way round-robin picker holding the last-grant pointer
module datamem_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic last_b;
  always_comb grant = req[0] && (!req[1] || last_b) ? 2'b01 : req[1] ? 2'b10 : 2'b00;
  // reset as if B had the last grant, so A takes the first tie
  always_ff @(posedge clk)
    if (rst) last_b <= 1'b1;
    else if (advance && |grant) last_b <= grant[1];
endmodule

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: two-port round-robin arbiter and load/store sequencer for the data memory
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int ADDR_BITWIDTH = 10
) (
  input  logic                     ARB_Clk,
  input  logic                     ARB_Reset,
  input  logic                     ARB_A_Req,
  input  logic                     ARB_A_We,
  input  logic [3:0]               ARB_A_Byteenable,
  input  logic [ADDR_BITWIDTH-1:0] ARB_A_Address,
  input  logic [31:0]              ARB_A_Wdata,
  input  logic                     ARB_B_Req,
  input  logic                     ARB_B_We,
  input  logic [3:0]               ARB_B_Byteenable,
  input  logic [ADDR_BITWIDTH-1:0] ARB_B_Address,
  input  logic [31:0]              ARB_B_Wdata,
  output logic                     ARB_A_Gnt,
  output logic                     ARB_B_Gnt,
  output logic                     ARB_A_Rvalid,
  output logic                     ARB_B_Rvalid,
  output logic [31:0]              ARB_A_Rdata,
  output logic [31:0]              ARB_B_Rdata,
  output logic                     ARB_A_Err,
  output logic                     ARB_B_Err,
  output logic                     ARB_MEM_We,
  output logic                     ARB_MEM_Re,
  output logic [3:0]               ARB_MEM_Byteenable,
  output logic [ADDR_BITWIDTH-1:0] ARB_MEM_Address,
  output logic [31:0]              ARB_MEM_Data_In,
  input  logic [31:0]              ARB_MEM_Data_Out
);
  state_t                   state;
  owner_t                   owner;
  logic [ADDR_BITWIDTH-1:0] lat_addr, g_addr;
  logic [3:0]               lat_be, g_be;
  logic [31:0]              g_wdata;
  logic [1:0]               pick, gnt;
  logic                     g_we, legal, go, load_go, store_go, resp;
  datamem_arb_rr u_rr (
    .clk    (ARB_Clk),
    .rst    (ARB_Reset),
    .advance(state == IDLE),
    .req    ({ARB_B_Req, ARB_A_Req}),
    .grant  (pick)
  );
  always_comb begin
    resp     = state == RD_RESP;
    gnt      = resp ? 2'b00 : pick;
    g_we     = gnt[1] ? ARB_B_We : ARB_A_We;
    g_be     = gnt[1] ? ARB_B_Byteenable : ARB_A_Byteenable;
    g_addr   = gnt[1] ? ARB_B_Address : ARB_A_Address;
    g_wdata  = gnt[1] ? ARB_B_Wdata : ARB_A_Wdata;
    legal    = is_legal(g_be, g_addr[1:0]);
    go       = |gnt && legal;
    load_go  = go && !g_we;
    store_go = go && g_we;
    // the read mux after the registered read needs address/BE held through RD_RESP
    ARB_MEM_We         = store_go;
    ARB_MEM_Re         = load_go || resp;
    ARB_MEM_Byteenable = resp ? lat_be : go ? g_be : 4'b0000;
    ARB_MEM_Address    = resp ? lat_addr : go ? g_addr : '0;
    ARB_MEM_Data_In    = store_go ? g_wdata : 32'd0;
  end
  assign ARB_A_Gnt = gnt[0];
  assign ARB_B_Gnt = gnt[1];
  always_ff @(posedge ARB_Clk)
    if (ARB_Reset) begin
      state        <= IDLE;
      owner        <= OWN_A;
      lat_addr     <= '0;
      lat_be       <= 4'b0000;
      ARB_A_Rvalid <= 1'b0;
      ARB_B_Rvalid <= 1'b0;
      ARB_A_Rdata  <= 32'd0;
      ARB_B_Rdata  <= 32'd0;
      ARB_A_Err    <= 1'b0;
      ARB_B_Err    <= 1'b0;
    end else begin
      state <= load_go ? RD_RESP : IDLE;
      if (load_go) begin
        lat_addr <= g_addr;
        lat_be   <= g_be;
        owner    <= gnt[1] ? OWN_B : OWN_A;
      end
      ARB_A_Rvalid <= resp && owner == OWN_A;
      ARB_B_Rvalid <= resp && owner == OWN_B;
      if (resp && owner == OWN_A) ARB_A_Rdata <= ARB_MEM_Data_Out;
      if (resp && owner == OWN_B) ARB_B_Rdata <= ARB_MEM_Data_Out;
      ARB_A_Err <= gnt[0] && !legal;
      ARB_B_Err <= gnt[1] && !legal;
    end
endmodule
